// File: rtl/cmd_relay_buffer.sv
// cmd_relay_buffer
//   Store-and-forward command relay. On cmd_ready it pulls a region of words
//   from an upstream read port (in_r_en / in_ptr / in_done), buffers up to
//   DEPTH words, pulses cmd_send, then serves random-access downstream reads
//   until cmd_done releases the buffer.
//
//   Optional feature macro: CMD_RELAY_CHKSUM_EN
//     Adds output chksum, the running XOR of every word stored for the
//     current command. Cleared on accept, valid from cmd_send until the next
//     accept.
module cmd_relay_buffer #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,               // power of two, >= 2
  localparam int IDX_W  = $clog2(DEPTH)     // derived, not to be overridden
) (
  input  logic              clk,
  input  logic              rst_L,
  // command handshake
  input  logic              cmd_ready,
  input  logic [IDX_W:0]    in_region_end,
  // upstream read port
  output logic              in_r_en,
  output logic [IDX_W-1:0]  in_ptr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_done,
  // downstream side
  output logic              cmd_send,
  output logic [IDX_W-1:0]  out_region_end,
  input  logic              out_r_en,
  input  logic [IDX_W-1:0]  out_ptr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_done,
  input  logic              cmd_done,
  // status
  output logic              busy,
  output logic              ovf
`ifdef CMD_RELAY_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [IDX_W-1:0]   index;      // next upstream word to fetch
  logic [IDX_W-1:0]   last_idx;   // clamped index of the final word
  logic [DATA_W-1:0]  mem [DEPTH];

  // decoded strobes from the next-state logic
  logic               accept;     // IDLE -> FILL this cycle
  logic               word_hit;   // upstream word arrives for an open request
  logic               fill_last;  // that word is the final one: FILL -> SEND
  logic               rd_fire;    // downstream read accepted this cycle

  // DEPTH is a power of two, so in_region_end >= DEPTH is exactly its MSB.
  logic               region_ovf;
  logic [IDX_W-1:0]   region_clamped;

  assign region_ovf     = in_region_end[IDX_W];
  assign region_clamped = region_ovf ? MAX_IDX : in_region_end[IDX_W-1:0];

  assign in_ptr = index;
  assign busy   = (state != ST_IDLE);

  // FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation races and sim/synthesis mismatches.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-cycle handshake strobes.
  // NOTE: every output of this block is given a default first so that no
  // path through the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    word_hit   = 1'b0;
    fill_last  = 1'b0;
    rd_fire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_ready) begin
          accept     = 1'b1;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        // in_done without an open request is stray and ignored
        word_hit  = in_r_en && in_done;
        fill_last = word_hit && (index == last_idx);
        if (fill_last) state_next = ST_SEND;
      end
      ST_SEND: begin
        // cmd_done wins over a coincident read: the read is dropped
        if (cmd_done) state_next = ST_IDLE;
        else          rd_fire    = out_r_en && !out_done;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Upstream fetch sequencing, command latching and status flags.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      index          <= '0;
      last_idx       <= '0;
      in_r_en        <= 1'b0;
      cmd_send       <= 1'b0;
      out_region_end <= '0;
      ovf            <= 1'b0;
    end else begin
      cmd_send <= 1'b0;

      if (accept) begin
        index    <= '0;
        last_idx <= region_clamped;
        ovf      <= region_ovf;
        in_r_en  <= 1'b0;
      end

      if (state == ST_FILL) begin
        if (word_hit) begin
          // close the request; a new one opens on the following cycle
          in_r_en <= 1'b0;
          if (fill_last) begin
            cmd_send       <= 1'b1;
            out_region_end <= last_idx;
            index          <= '0;
          end else begin
            index <= index + 1'b1;
          end
        end else if (!in_r_en && (index <= last_idx)) begin
          in_r_en <= 1'b1;
        end
      end
    end
  end

  // Command word storage.
  // NOTE: the buffer is cleared on reset so a read after an aborted command
  // can never return stale data; this costs a reset on every word flop,
  // which rules out mapping the array onto a RAM macro.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (word_hit) begin
      mem[index] <= in_data;
    end
  end

  // Downstream read port: one-cycle strobe, data held between strobes.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      out_done <= 1'b0;
      out_data <= '0;
    end else begin
      out_done <= 1'b0;
      if (rd_fire) begin
        out_done <= 1'b1;
        out_data <= (out_ptr > last_idx) ? '0 : mem[out_ptr];
      end
    end
  end

`ifdef CMD_RELAY_CHKSUM_EN
  // Running XOR of the words stored for the current command.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)        chksum <= '0;
    else if (accept)   chksum <= '0;
    else if (word_hit) chksum <= chksum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_cmd_relay_buffer.sv
// tb_cmd_relay_buffer
//   Directed bench for cmd_relay_buffer. Expected downstream read data is
//   pushed to a scoreboard queue when a read is issued and popped when the
//   DUT strobes out_done. Define CMD_RELAY_CHKSUM_EN to cover chksum.
module tb_cmd_relay_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_L;
  logic              cmd_ready;
  logic [IDX_W:0]    in_region_end;
  logic              in_r_en;
  logic [IDX_W-1:0]  in_ptr;
  logic [DATA_W-1:0] in_data;
  logic              in_done;
  logic              cmd_send;
  logic [IDX_W-1:0]  out_region_end;
  logic              out_r_en;
  logic [IDX_W-1:0]  out_ptr;
  logic [DATA_W-1:0] out_data;
  logic              out_done;
  logic              cmd_done;
  logic              busy;
  logic              ovf;
`ifdef CMD_RELAY_CHKSUM_EN
  logic [DATA_W-1:0] chksum;
  logic [DATA_W-1:0] chk_at_send;
`endif

  cmd_relay_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_L          (rst_L),
    .cmd_ready      (cmd_ready),
    .in_region_end  (in_region_end),
    .in_r_en        (in_r_en),
    .in_ptr         (in_ptr),
    .in_data        (in_data),
    .in_done        (in_done),
    .cmd_send       (cmd_send),
    .out_region_end (out_region_end),
    .out_r_en       (out_r_en),
    .out_ptr        (out_ptr),
    .out_data       (out_data),
    .out_done       (out_done),
    .cmd_done       (cmd_done),
    .busy           (busy),
    .ovf            (ovf)
`ifdef CMD_RELAY_CHKSUM_EN
    ,
    .chksum         (chksum)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int send_cnt = 0;
  int done_cnt = 0;

  logic [DATA_W-1:0] up_words [32];
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model of a downstream read.
  function automatic logic [DATA_W-1:0] exp_word(input int ptr, input int last);
    return (ptr > last) ? '0 : up_words[ptr];
  endfunction

  // Scoreboard consumer and pulse counters.
  always @(negedge clk) begin
    if (rst_L === 1'b1 && out_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_out_done", 64'd1, 64'd0);
      else                   check("out_data", out_data, exp_q.pop_front());
    end
    if (cmd_send === 1'b1) send_cnt++;
  end

  // Issue a command and act as the upstream port until cmd_send, or until
  // a request for index abort_at appears (left unanswered).
  task automatic run_fill(input int region_end, input int delay, input int abort_at,
                          output int n_req, output bit seq_ok, output bit held_ok,
                          output bit timed_out);
    int               budget;
    int               exp_ptr;
    bit               fin;
    logic [IDX_W-1:0] p;
    n_req = 0; seq_ok = 1'b1; held_ok = 1'b1; timed_out = 1'b0;
    exp_ptr = 0; fin = 1'b0; budget = 400;
    in_region_end = region_end[IDX_W:0];
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    while (!fin) begin
      if (budget <= 0) begin
        timed_out = 1'b1;
        fin = 1'b1;
      end else begin
        @(negedge clk);
        budget--;
        in_done = 1'b0;
        if (cmd_send) begin
          fin = 1'b1;
`ifdef CMD_RELAY_CHKSUM_EN
          chk_at_send = chksum;
`endif
        end else if (in_r_en) begin
          p = in_ptr;
          if (int'(p) == abort_at) begin
            fin = 1'b1;
          end else begin
            n_req++;
            if (int'(p) != exp_ptr) seq_ok = 1'b0;
            exp_ptr++;
            for (int d = 0; d < delay; d++) begin
              @(negedge clk);
              budget--;
              if (!in_r_en || in_ptr != p) held_ok = 1'b0;
            end
            in_data = up_words[p];
            in_done = 1'b1;
          end
        end
      end
    end
  endtask

  // Single downstream read; the scoreboard compares the data.
  task automatic do_read(input int ptr, input logic [DATA_W-1:0] exp_v);
    out_r_en = 1'b1;
    out_ptr  = ptr[IDX_W-1:0];
    exp_q.push_back(exp_v);
    @(negedge clk);
    out_r_en = 1'b0;
    check("rd_latency", out_done, 1);
    @(negedge clk);
    check("rd_pulse_end", out_done, 0);
  endtask

  task automatic release_cmd();
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    check("busy_after_cmd_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_req, s0, d0;
    bit  seq_ok, held_ok, timed_out;

    rst_L = 1'b0; cmd_ready = 1'b0; in_region_end = '0; in_data = '0;
    in_done = 1'b0; out_r_en = 1'b0; out_ptr = '0; cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_r_en", in_r_en, 0);
    check("rst_cmd_send", cmd_send, 0);
    check("rst_out_done", out_done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);
`ifdef CMD_RELAY_CHKSUM_EN
    check("rst_chksum", chksum, 0);
`endif
    rst_L = 1'b1;
    @(negedge clk);

    // T1: four-word command, single-cycle upstream latency
    for (int i = 0; i < 4; i++) up_words[i] = 32'hA000_00A0 + i;
    s0 = send_cnt;
    run_fill(3, 0, -1, n_req, seq_ok, held_ok, timed_out);
    check("t1_timeout", timed_out, 0);
    check("t1_n_req", n_req, 4);
    check("t1_ptr_seq", seq_ok, 1);
    check("t1_out_region_end", out_region_end, 3);
    check("t1_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    check("t1_send_once", send_cnt - s0, 1);
    do_read(2, exp_word(2, 3));

    // out-of-range pointer, out_r_en held 6 cycles: 3 zero strobes
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    d0 = done_cnt;
    out_ptr = 4'd4; out_r_en = 1'b1;
    repeat (6) @(negedge clk);
    out_r_en = 1'b0;
    repeat (2) @(negedge clk);
    check("held_strobes", done_cnt - d0, 3);
    check("held_q_empty", exp_q.size(), 0);
    release_cmd();

    // T2: region beyond DEPTH is clamped
    for (int i = 0; i < 20; i++) up_words[i] = 32'hB000_0000 + i * 17;
    run_fill(DEPTH + 4, 0, -1, n_req, seq_ok, held_ok, timed_out);
    check("t2_timeout", timed_out, 0);
    check("t2_n_req", n_req, DEPTH);
    check("t2_ptr_seq", seq_ok, 1);
    check("t2_ovf", ovf, 1);
    check("t2_out_region_end", out_region_end, DEPTH - 1);
    do_read(DEPTH - 1, exp_word(DEPTH - 1, DEPTH - 1));
    do_read(0, exp_word(0, DEPTH - 1));
    // cmd_done with a coincident read: read dropped
    d0 = done_cnt;
    out_ptr = 4'd3; out_r_en = 1'b1; cmd_done = 1'b1;
    @(negedge clk);
    out_r_en = 1'b0; cmd_done = 1'b0;
    check("t2_drop_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("t2_drop_no_strobe", done_cnt - d0, 0);

    // T3: slow upstream, ovf cleared by the new accept
    for (int i = 0; i < 6; i++) up_words[i] = $urandom;
    run_fill(5, 5, -1, n_req, seq_ok, held_ok, timed_out);
    check("t3_timeout", timed_out, 0);
    check("t3_n_req", n_req, 6);
    check("t3_ptr_seq", seq_ok, 1);
    check("t3_r_en_held", held_ok, 1);
    check("t3_ovf_cleared", ovf, 0);
    for (int p = 0; p < 6; p++) do_read(p, exp_word(p, 5));
    do_read(9, exp_word(9, 5));
    release_cmd();

    // T4: asynchronous reset while index 2 is requested
    for (int i = 0; i < 6; i++) up_words[i] = 32'hC0DE_0000 + i;
    s0 = send_cnt;
    run_fill(5, 0, 2, n_req, seq_ok, held_ok, timed_out);
    check("t4_reached_idx2", in_r_en, 1);
    rst_L = 1'b0;
    #1;
    check("t4_rst_in_r_en", in_r_en, 0);
    check("t4_rst_in_ptr", in_ptr, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_out_data", out_data, 0);
    check("t4_rst_out_region_end", out_region_end, 0);
    check("t4_rst_cmd_send", cmd_send, 0);
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    check("t4_no_cmd_send", send_cnt - s0, 0);
    for (int i = 0; i < 6; i++) up_words[i] = 32'hD00D_0000 + i * 3;
    run_fill(5, 0, -1, n_req, seq_ok, held_ok, timed_out);
    check("t4_restart_timeout", timed_out, 0);
    check("t4_restart_n_req", n_req, 6);
    check("t4_restart_seq", seq_ok, 1);
    do_read(0, exp_word(0, 5));
    do_read(5, exp_word(5, 5));
    release_cmd();

`ifdef CMD_RELAY_CHKSUM_EN
    // T5: checksum of 0x1, 0x2, 0x4
    up_words[0] = 32'h1; up_words[1] = 32'h2; up_words[2] = 32'h4;
    run_fill(2, 0, -1, n_req, seq_ok, held_ok, timed_out);
    check("t5_timeout", timed_out, 0);
    check("t5_chksum", chk_at_send, 32'h7);
    release_cmd();
`endif

    repeat (2) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
